// File: rtl/psg_register_writer.sv
// SN76489-style latch/data byte decoder for the PSG control registers.
// A valid/ready handshake with a programmable busy window stands in for the chip's READY pin.
module psg_register_writer #(
    parameter int ATTENUATION_CONTROL_BITS = 4,
    parameter int FREQUENCY_COUNTER_BITS   = 10,
    parameter int NOISE_CONTROL_BITS       = 3,
    parameter int BUSY_CYCLES              = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [7:0]                            wr_data,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    output logic [4*ATTENUATION_CONTROL_BITS-1:0] attn_o,
    output logic [3*FREQUENCY_COUNTER_BITS-1:0]   tone_freq_o,
    output logic [NOISE_CONTROL_BITS-1:0]         noise_ctrl_o,
    output logic                                  noise_lfsr_reset,
    output logic [2:0]                            latched_reg_o
);
    localparam int AW = ATTENUATION_CONTROL_BITS;
    localparam int FW = FREQUENCY_COUNTER_BITS;
    localparam int NW = NOISE_CONTROL_BITS;
    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [1:0] chan;
        logic       is_attn;
    } latch_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      busy_cnt_q, busy_cnt_d;
    logic [3:0][AW-1:0] attn_q, attn_d;
    logic [2:0][FW-1:0] tone_q, tone_d;
    logic [NW-1:0]      noise_q, noise_d;
    latch_t             latch_q, latch_d;
    logic               lfsr_rst_q, lfsr_rst_d;
    latch_t             target;
    logic               xfer;

    assign wr_ready = (state_q == IDLE);
    assign xfer     = wr_valid && wr_ready;

    // Busy window: counter is loaded with N-1 so ready stays low for exactly N cycles.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer && (BUSY_CYCLES > 0)) begin
                    state_d    = BUSY;
                    busy_cnt_d = CW'(BUSY_CYCLES - 1);
                end
            end
            BUSY: begin
                if (busy_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A latch byte retargets first, so both byte kinds share the same register write path.
    always_comb begin
        attn_d     = attn_q;
        tone_d     = tone_q;
        noise_d    = noise_q;
        latch_d    = latch_q;
        lfsr_rst_d = 1'b0;
        target     = latch_q;
        if (xfer) begin
            if (wr_data[7]) begin
                target  = {wr_data[6:5], wr_data[4]};
                latch_d = target;
            end
            if (target.is_attn) begin
                attn_d[target.chan] = AW'(wr_data[3:0]);
            end else if (target.chan == 2'd3) begin
                noise_d    = NW'(wr_data[2:0]);
                lfsr_rst_d = 1'b1;
            end else if (wr_data[7]) begin
                tone_d[target.chan][3:0] = wr_data[3:0];
            end else begin
                tone_d[target.chan] = {(FW-4)'(wr_data[5:0]), tone_q[target.chan][3:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
            attn_q     <= '1;
            tone_q     <= '0;
            noise_q    <= '0;
            latch_q    <= '0;
            lfsr_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            attn_q     <= attn_d;
            tone_q     <= tone_d;
            noise_q    <= noise_d;
            latch_q    <= latch_d;
            lfsr_rst_q <= lfsr_rst_d;
        end
    end

    assign attn_o           = attn_q;
    assign tone_freq_o      = tone_q;
    assign noise_ctrl_o     = noise_q;
    assign noise_lfsr_reset = lfsr_rst_q;
    assign latched_reg_o    = latch_q;

endmodule

// File: tb/tb_psg_register_writer.sv
// Scoreboard bench: u0 runs with no busy window (back-to-back writes), u1 with a 32-cycle window.
module tb_psg_register_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  d0, d1;
    logic        v0, v1, rdy0, rdy1, pulse0, pulse1;
    logic [15:0] attn0, attn1;
    logic [29:0] tone0, tone1;
    logic [2:0]  nz0, nz1, lat0, lat1;

    psg_register_writer #(.BUSY_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .wr_data(d0), .wr_valid(v0), .wr_ready(rdy0),
        .attn_o(attn0), .tone_freq_o(tone0), .noise_ctrl_o(nz0),
        .noise_lfsr_reset(pulse0), .latched_reg_o(lat0));

    psg_register_writer #(.BUSY_CYCLES(32)) u1 (
        .clk(clk), .reset(reset), .wr_data(d1), .wr_valid(v1), .wr_ready(rdy1),
        .attn_o(attn1), .tone_freq_o(tone1), .noise_ctrl_o(nz1),
        .noise_lfsr_reset(pulse1), .latched_reg_o(lat1));

    typedef struct packed {
        logic [15:0] attn;
        logic [29:0] tone;
        logic [2:0]  noise;
        logic [2:0]  lat;
        logic        pulse;
    } exp_t;

    exp_t q0[$], q1[$];
    int   acc1[$];
    int   vectors = 0, errors = 0, cyc = 0;
    bit   mon_en = 1'b0;
    bit   pend0 = 1'b0, pend1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic [29:0] t,
                                input logic [2:0] n, input logic [2:0] l, input logic p);
        return '{a, t, n, l, p};
    endfunction

    // Monitors: a transfer seen before a posedge is checked at the following negedge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (pend0) begin
                if (q0.size() == 0) chk("u0_unexpected_accept", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("u0_attn", attn0, e.attn);
                    chk("u0_tone", tone0, e.tone);
                    chk("u0_noise", nz0, e.noise);
                    chk("u0_latched", lat0, e.lat);
                    chk("u0_lfsr_pulse", pulse0, e.pulse);
                end
            end else chk("u0_pulse_idle", pulse0, 0);
            pend0 = v0 && rdy0 && !reset;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (pend1) begin
                acc1.push_back(cyc);
                if (q1.size() == 0) chk("u1_unexpected_accept", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("u1_attn", attn1, e.attn);
                    chk("u1_tone", tone1, e.tone);
                    chk("u1_noise", nz1, e.noise);
                    chk("u1_latched", lat1, e.lat);
                    chk("u1_lfsr_pulse", pulse1, e.pulse);
                end
            end else chk("u1_pulse_idle", pulse1, 0);
            pend1 = v1 && rdy1 && !reset;
        end
    end

    // Back-to-back on u0: the byte is taken at the very next posedge.
    task automatic send0(input logic [7:0] b, input exp_t e);
        q0.push_back(e);
        d0 = b;
        v0 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_rdy1(input string name);
        int k = 0;
        while (!rdy1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, rdy1, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_u0_attn"}, attn0, 16'hFFFF);
        chk({tag, "_u0_tone"}, tone0, 0);
        chk({tag, "_u0_noise"}, nz0, 0);
        chk({tag, "_u0_latched"}, lat0, 0);
        chk({tag, "_u0_ready"}, rdy0, 1);
        chk({tag, "_u1_attn"}, attn1, 16'hFFFF);
        chk({tag, "_u1_tone"}, tone1, 0);
        chk({tag, "_u1_noise"}, nz1, 0);
        chk({tag, "_u1_latched"}, lat1, 0);
        chk({tag, "_u1_ready"}, rdy1, 1);
        chk({tag, "_u1_pulse"}, pulse1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lo;
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");
        mon_en = 1'b1;
        @(posedge clk); #1;

        // u0: tone0, attn1, noise, tone2 (data bit6 ignored), attn3; valid never drops.
        send0(8'h8E, mk(16'hFFFF, 30'h000000E, 3'b000, 3'b000, 1'b0));
        send0(8'h0F, mk(16'hFFFF, 30'h00000FE, 3'b000, 3'b000, 1'b0));
        send0(8'h3F, mk(16'hFFFF, 30'h00003FE, 3'b000, 3'b000, 1'b0));
        send0(8'hB5, mk(16'hFF5F, 30'h00003FE, 3'b000, 3'b011, 1'b0));
        send0(8'h02, mk(16'hFF2F, 30'h00003FE, 3'b000, 3'b011, 1'b0));
        send0(8'hE5, mk(16'hFF2F, 30'h00003FE, 3'b101, 3'b110, 1'b1));
        send0(8'h06, mk(16'hFF2F, 30'h00003FE, 3'b110, 3'b110, 1'b1));
        send0(8'hC7, mk(16'hFF2F, 30'h007003FE, 3'b110, 3'b100, 1'b0));
        send0(8'h7A, mk(16'hFF2F, 30'h3A7003FE, 3'b110, 3'b100, 1'b0));
        send0(8'hF0, mk(16'h0F2F, 30'h3A7003FE, 3'b110, 3'b111, 1'b0));
        v0 = 1'b0;
        repeat (2) @(posedge clk); #1;

        // u1: valid held across the busy window.
        q1.push_back(mk(16'hFFFF, 30'h1, 3'b000, 3'b000, 1'b0));
        d1 = 8'h81; v1 = 1'b1;
        @(posedge clk); #1;
        q1.push_back(mk(16'hFFFF, 30'h5, 3'b000, 3'b000, 1'b0));
        d1 = 8'h85;
        lo = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy1) break;
            lo++;
        end
        chk("busy_low_cycles", lo, 32);
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        if (acc1.size() >= 2) chk("accept_spacing", acc1[1] - acc1[0], 33);
        else chk("accept_count", acc1.size(), 2);

        // Reset ten cycles into a busy window.
        wait_rdy1("u1_ready_before_90");
        q1.push_back(mk(16'hFFF0, 30'h5, 3'b000, 3'b001, 1'b0));
        d1 = 8'h90; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_state("midbusy");

        // Transfer and reset in the same cycle: reset must win.
        @(posedge clk); #1;
        reset = 1'b1; d0 = 8'hB0; v0 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; v0 = 1'b0;
        @(negedge clk);
        chk("xfer_reset_u0_attn", attn0, 16'hFFFF);
        chk("xfer_reset_u0_latched", lat0, 0);

        repeat (2) @(posedge clk); #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
